// File: rtl/icache_2way.sv
// 2-way set-associative instruction cache with per-set LRU, refill drain across ROB flush,
// and whole-cache invalidate for fence.i.
module icache_2way #(
    parameter int unsigned SET_BITS   = 6,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  req_valid_from_iq,
    input  logic [ADDR_WIDTH-1:0] pc_from_iq,
    output logic                  req_ready_to_iq,
    output logic                  instr_valid_to_iq,
    output logic [DATA_WIDTH-1:0] instr_to_iq,
    output logic                  mem_req_to_fc,
    output logic [ADDR_WIDTH-1:0] addr_to_fc,
    input  logic                  mem_done_from_fc,
    input  logic [DATA_WIDTH-1:0] instr_from_fc,
    input  logic                  flush_from_rob,
    input  logic                  invalidate_from_ctrl
);
    localparam int unsigned SETS  = 1 << SET_BITS;
    localparam int unsigned TAG_W = ADDR_WIDTH - SET_BITS - 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MISS  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [SETS-1:0]       valid0_q, valid1_q, lru_q;
    logic [TAG_W-1:0]      tag0_q  [SETS];
    logic [TAG_W-1:0]      tag1_q  [SETS];
    logic [DATA_WIDTH-1:0] data0_q [SETS];
    logic [DATA_WIDTH-1:0] data1_q [SETS];

    logic [1:0]            state_q;
    logic                  pend_inval_q;
    logic                  instr_valid_q;
    logic                  mem_req_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic [SET_BITS-1:0] req_set, fill_set;
    logic [TAG_W-1:0]    req_tag, fill_tag;
    logic                hit0, hit1, victim, in_fill, clear_all, accept;
    logic                unused_pc_bits;

    assign req_set  = pc_from_iq[SET_BITS+1:2];
    assign req_tag  = pc_from_iq[ADDR_WIDTH-1:SET_BITS+2];
    assign fill_set = addr_q[SET_BITS+1:2];
    assign fill_tag = addr_q[ADDR_WIDTH-1:SET_BITS+2];
    assign unused_pc_bits = ^pc_from_iq[1:0];

    assign hit0 = valid0_q[req_set] && (tag0_q[req_set] == req_tag);
    assign hit1 = valid1_q[req_set] && (tag1_q[req_set] == req_tag);

    // Prefer an empty way; fall back to the LRU victim only when the set is full.
    assign victim = !valid0_q[fill_set] ? 1'b0 :
                    !valid1_q[fill_set] ? 1'b1 : lru_q[fill_set];

    assign in_fill   = rdy && (state_q != IDLE) && mem_done_from_fc;
    assign clear_all = rdy && (state_q == IDLE) && (pend_inval_q || invalidate_from_ctrl);

    assign req_ready_to_iq = rdy && (state_q == IDLE) && !flush_from_rob &&
                             !invalidate_from_ctrl && !pend_inval_q;
    assign accept = req_ready_to_iq && req_valid_from_iq;

    assign instr_valid_to_iq = instr_valid_q;
    assign instr_to_iq       = instr_q;
    assign mem_req_to_fc     = mem_req_q;
    assign addr_to_fc        = addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid0_q      <= '0;
            valid1_q      <= '0;
            lru_q         <= '0;
            state_q       <= IDLE;
            pend_inval_q  <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            mem_req_q     <= 1'b0;
            addr_q        <= '0;
        end else if (rdy) begin
            instr_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_all) begin
                        valid0_q     <= '0;
                        valid1_q     <= '0;
                        lru_q        <= '0;
                        pend_inval_q <= 1'b0;
                    end else if (accept) begin
                        if (hit0 || hit1) begin
                            instr_valid_q  <= 1'b1;
                            instr_q        <= hit0 ? data0_q[req_set] : data1_q[req_set];
                            lru_q[req_set] <= hit0;
                        end else begin
                            state_q   <= MISS;
                            mem_req_q <= 1'b1;
                            addr_q    <= {pc_from_iq[ADDR_WIDTH-1:2], 2'b00};
                        end
                    end
                end
                MISS, DRAIN: begin
                    if (invalidate_from_ctrl) pend_inval_q <= 1'b1;
                    if (mem_done_from_fc) begin
                        if (victim) valid1_q[fill_set] <= 1'b1;
                        else        valid0_q[fill_set] <= 1'b1;
                        lru_q[fill_set] <= ~victim;
                        state_q         <= IDLE;
                        mem_req_q       <= 1'b0;
                        // A flush landing with the fill, or an earlier one (DRAIN), drops the reply.
                        if (state_q == MISS && !flush_from_rob) begin
                            instr_valid_q <= 1'b1;
                            instr_q       <= instr_from_fc;
                        end
                    end else if (flush_from_rob) begin
                        state_q <= DRAIN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_fill) begin
            if (victim) begin
                tag1_q[fill_set]  <= fill_tag;
                data1_q[fill_set] <= instr_from_fc;
            end else begin
                tag0_q[fill_set]  <= fill_tag;
                data0_q[fill_set] <= instr_from_fc;
            end
        end
    end

endmodule

// File: tb/tb_icache_2way.sv
// Bench for icache_2way: directed scenarios plus random fetches checked against a
// per-set two-entry LRU cache model.
module tb_icache_2way;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] pc_in = '0;
    logic        req_ready;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic        mem_req;
    logic [31:0] addr_fc;
    logic        mem_done = 1'b0;
    logic [31:0] instr_fc = '0;
    logic        flush = 1'b0;
    logic        inval = 1'b0;

    int checks = 0;
    int errors = 0;

    bit          m_valid [64][2];
    logic [23:0] m_tag   [64][2];
    logic [31:0] m_data  [64][2];
    bit          m_lru   [64];

    icache_2way dut (
        .clk                  (clk),
        .rst                  (rst),
        .rdy                  (rdy),
        .req_valid_from_iq    (req_valid),
        .pc_from_iq           (pc_in),
        .req_ready_to_iq      (req_ready),
        .instr_valid_to_iq    (instr_valid),
        .instr_to_iq          (instr_out),
        .mem_req_to_fc        (mem_req),
        .addr_to_fc           (addr_fc),
        .mem_done_from_fc     (mem_done),
        .instr_from_fc        (instr_fc),
        .flush_from_rob       (flush),
        .invalidate_from_ctrl (inval)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_inval();
        for (int s = 0; s < 64; s++) begin
            m_valid[s][0] = 0;
            m_valid[s][1] = 0;
            m_lru[s]      = 0;
        end
    endtask

    task automatic model_lookup(input logic [31:0] pc, output bit hit, output int way);
        int s;
        s   = int'(pc[7:2]);
        hit = 0;
        way = 0;
        for (int w = 1; w >= 0; w--)
            if (m_valid[s][w] && m_tag[s][w] == pc[31:8]) begin
                hit = 1;
                way = w;
            end
    endtask

    task automatic model_fill(input logic [31:0] pc, input logic [31:0] d);
        int s, v;
        s = int'(pc[7:2]);
        if (!m_valid[s][0])      v = 0;
        else if (!m_valid[s][1]) v = 1;
        else                     v = m_lru[s] ? 1 : 0;
        m_valid[s][v] = 1;
        m_tag[s][v]   = pc[31:8];
        m_data[s][v]  = d;
        m_lru[s]      = (v == 0);
    endtask

    // Full request: wait for ready, then check hit or miss/refill against the model.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] fdata, input int delay);
        int n, way, s;
        bit hit;
        s = int'(pc[7:2]);
        req_valid = 1'b1;
        pc_in     = pc;
        #1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        check("req_ready", {31'b0, req_ready}, 32'd1);
        model_lookup(pc, hit, way);
        tick();
        req_valid = 1'b0;
        if (hit) begin
            check("hit_valid", {31'b0, instr_valid}, 32'd1);
            check("hit_data", instr_out, m_data[s][way]);
            check("hit_no_memreq", {31'b0, mem_req}, 32'd0);
            m_lru[s] = (way == 0);
        end else begin
            check("miss_valid", {31'b0, instr_valid}, 32'd0);
            check("miss_memreq", {31'b0, mem_req}, 32'd1);
            check("miss_addr", addr_fc, {pc[31:2], 2'b00});
            for (int i = 0; i < delay; i++) begin
                tick();
                check("miss_hold", {31'b0, mem_req}, 32'd1);
            end
            mem_done = 1'b1;
            instr_fc = fdata;
            tick();
            mem_done = 1'b0;
            check("fill_valid", {31'b0, instr_valid}, 32'd1);
            check("fill_data", instr_out, fdata);
            check("fill_memreq_low", {31'b0, mem_req}, 32'd0);
            model_fill(pc, fdata);
        end
    endtask

    initial begin
        int s;
        logic [31:0] d, pc;
        model_inval();

        // Reset state
        repeat (2) tick();
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_memreq", {31'b0, mem_req}, 32'd0);
        check("rst_addr", addr_fc, 32'd0);
        rst = 1'b1;
        tick();
        #1;
        check("ready_after_rst", {31'b0, req_ready}, 32'd1);

        // Miss then hit on 0x1000
        fetch(32'h1000, 32'h0010_0093, 2);
        fetch(32'h1000, 32'h0, 0);

        // LRU victim selection within set 0
        fetch(32'h2000, 32'hAAAA_2000, 1);
        fetch(32'h1000, 32'h0, 0);
        fetch(32'h3000, 32'hAAAA_3000, 0);
        fetch(32'h1000, 32'h0, 0);
        fetch(32'h2000, 32'hBBBB_2000, 1);

        // Flush during MISS: the refill completes silently
        req_valid = 1'b1;
        pc_in     = 32'h4000;
        #1;
        check("flush_req_ready", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("flush_miss_memreq", {31'b0, mem_req}, 32'd1);
        tick();
        flush = 1'b1;
        #1;
        check("flush_ready_low", {31'b0, req_ready}, 32'd0);
        tick();
        flush = 1'b0;
        check("drain_memreq", {31'b0, mem_req}, 32'd1);
        tick();
        tick();
        mem_done = 1'b1;
        instr_fc = 32'hCAFE_4000;
        tick();
        mem_done = 1'b0;
        check("drain_no_resp", {31'b0, instr_valid}, 32'd0);
        check("drain_memreq_low", {31'b0, mem_req}, 32'd0);
        #1;
        check("drain_idle_ready", {31'b0, req_ready}, 32'd1);
        model_fill(32'h4000, 32'hCAFE_4000);
        fetch(32'h4000, 32'h0, 0);

        // Back-to-back hits
        fetch(32'h1004, 32'h1111_1004, 0);
        fetch(32'h1008, 32'h1111_1008, 1);
        fetch(32'h1000, 32'h1111_1000, 0);
        for (int i = 0; i < 3; i++) begin
            bit hit;
            int way;
            pc = 32'h1000 + 32'(4 * i);
            s  = int'(pc[7:2]);
            req_valid = 1'b1;
            pc_in     = pc;
            #1;
            check("b2b_ready", {31'b0, req_ready}, 32'd1);
            model_lookup(pc, hit, way);
            d = hit ? m_data[s][way] : 32'hDEAD_DEAD;
            if (hit) m_lru[s] = (way == 0);
            tick();
            check("b2b_valid", {31'b0, instr_valid}, 32'd1);
            check("b2b_data", instr_out, d);
        end
        req_valid = 1'b0;

        // Invalidate during MISS
        req_valid = 1'b1;
        pc_in     = 32'h5000;
        #1;
        check("inv_req_ready", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("inv_miss_memreq", {31'b0, mem_req}, 32'd1);
        inval = 1'b1;
        tick();
        inval = 1'b0;
        tick();
        mem_done = 1'b1;
        instr_fc = 32'h5555_0001;
        tick();
        mem_done = 1'b0;
        check("inv_resp_valid", {31'b0, instr_valid}, 32'd1);
        check("inv_resp_data", instr_out, 32'h5555_0001);
        req_valid = 1'b1;
        pc_in     = 32'h5000;
        #1;
        check("inv_ready_low", {31'b0, req_ready}, 32'd0);
        req_valid = 1'b0;
        tick();
        #1;
        check("inv_ready_back", {31'b0, req_ready}, 32'd1);
        model_inval();
        fetch(32'h5000, 32'h5555_0002, 1);

        // rdy low freezes a MISS even with mem_done asserted
        req_valid = 1'b1;
        pc_in     = 32'h6000;
        #1;
        tick();
        req_valid = 1'b0;
        check("rdy_miss_memreq", {31'b0, mem_req}, 32'd1);
        rdy      = 1'b0;
        mem_done = 1'b1;
        instr_fc = 32'h6666_6666;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rdy_freeze_memreq", {31'b0, mem_req}, 32'd1);
            check("rdy_freeze_valid", {31'b0, instr_valid}, 32'd0);
        end
        rdy = 1'b1;
        tick();
        mem_done = 1'b0;
        check("rdy_fill_valid", {31'b0, instr_valid}, 32'd1);
        check("rdy_fill_data", instr_out, 32'h6666_6666);
        check("rdy_fill_memreq", {31'b0, mem_req}, 32'd0);
        model_fill(32'h6000, 32'h6666_6666);
        fetch(32'h6000, 32'h0, 0);

        // Random fetches over a few colliding sets, with occasional invalidates
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                inval     = 1'b1;
                req_valid = 1'b1;
                pc_in     = 32'h100;
                #1;
                check("rnd_inv_ready", {31'b0, req_ready}, 32'd0);
                tick();
                inval     = 1'b0;
                req_valid = 1'b0;
                check("rnd_inv_no_resp", {31'b0, instr_valid}, 32'd0);
                model_inval();
            end else begin
                pc = (32'($urandom_range(1, 4)) << 8) | (32'($urandom_range(0, 3)) << 2) |
                     32'($urandom_range(0, 3));
                fetch(pc, $urandom, $urandom_range(0, 3));
            end
        end

        // Asynchronous reset mid-MISS
        req_valid = 1'b1;
        pc_in     = 32'h7000;
        #1;
        tick();
        req_valid = 1'b0;
        check("arst_miss_memreq", {31'b0, mem_req}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_memreq", {31'b0, mem_req}, 32'd0);
        check("arst_addr", addr_fc, 32'd0);
        tick();
        rst = 1'b1;
        model_inval();
        fetch(32'h1000, 32'h0010_0093, 1);
        fetch(32'h1000, 32'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
